// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR write-back front end.
package gpr_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    // One buffered result: destination register plus data.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which buffer owns the GPR write port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_MEM  = 2'd2
    } src_sel_t;

    // True when a pending entry targets the given register.
    function automatic logic entry_hits(input wb_entry_t e, input logic [ADDR_W-1:0] addr);
        return e.valid && (e.dest == addr);
    endfunction

endpackage

// File: rtl/gpr_writeback_unit_wb_slot.sv
// Single-entry result buffer with a valid/ready input side.
// Handshake: a result moves into the slot on the rising edge where
// in_valid && in_ready; the producer holds in_valid and its payload until then.
// The slot can take a new result in the same cycle its current one drains.
module wb_slot
    import gpr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              in_ready,
    output logic              load,
    output wb_entry_t         entry
);

    assign in_ready = !rst && (!entry.valid || drain);
    assign load     = in_valid && in_ready;

    // Capture a new result, or empty the slot once its result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
        end else if (load) begin
            entry.valid <= 1'b1;
            entry.dest  <= in_dest;
            entry.data  <= in_data;
        end else if (drain) begin
            entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_writeback_unit.sv
// Write-side front end of the 8x8 GPR block: buffers ALU and load results,
// arbitrates them onto the single GPR write port and forwards pending
// results onto both operand read ports.
module gpr_writeback_unit #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2
);
    import gpr_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    wb_entry_t        alu_buf;
    wb_entry_t        mem_buf;
    logic             alu_load;
    logic             mem_load;
    src_sel_t         sel;
    logic             alu_drain;
    logic             mem_drain;
    logic [CNT_W-1:0] starve_cnt;
    // Set when the ALU entry is older than the mem entry.
    logic             alu_older;
    wb_entry_t        younger_buf;
    wb_entry_t        older_buf;

    assign alu_drain = (sel == SEL_ALU);
    assign mem_drain = (sel == SEL_MEM);

    wb_slot u_alu_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (alu_valid),
        .in_dest  (alu_dest),
        .in_data  (alu_data),
        .drain    (alu_drain),
        .in_ready (alu_ready),
        .load     (alu_load),
        .entry    (alu_buf)
    );

    wb_slot u_mem_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (mem_valid),
        .in_dest  (mem_dest),
        .in_data  (mem_data),
        .drain    (mem_drain),
        .in_ready (mem_ready),
        .load     (mem_load),
        .entry    (mem_buf)
    );

    // Pick the buffer that owns the write port: same-dest pairs go oldest
    // first, otherwise ALU wins unless mem has starved long enough.
    always_comb begin
        sel = SEL_NONE;
        if (alu_buf.valid && mem_buf.valid) begin
            if (alu_buf.dest == mem_buf.dest) begin
                sel = alu_older ? SEL_ALU : SEL_MEM;
            end else begin
                sel = (starve_cnt == CNT_MAX) ? SEL_MEM : SEL_ALU;
            end
        end else if (alu_buf.valid) begin
            sel = SEL_ALU;
        end else if (mem_buf.valid) begin
            sel = SEL_MEM;
        end
    end

    // Track relative age: a fresh load is younger than whatever it joins;
    // on a simultaneous load mem is treated as the older one.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_older <= 1'b0;
        end else if (alu_load) begin
            alu_older <= 1'b0;
        end else if (mem_load) begin
            alu_older <= 1'b1;
        end
    end

    // Count consecutive lost arbitrations of a waiting mem entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!mem_buf.valid || mem_drain) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Register the selected entry onto the GPR write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            reg_write_en <= (sel != SEL_NONE);
            if (alu_drain) begin
                reg_write_dest <= alu_buf.dest;
                reg_write_data <= alu_buf.data;
            end else if (mem_drain) begin
                reg_write_dest <= mem_buf.dest;
                reg_write_data <= mem_buf.data;
            end
        end
    end

    assign younger_buf = alu_older ? mem_buf : alu_buf;
    assign older_buf   = alu_older ? alu_buf : mem_buf;

    // Youngest pending value for one read port; lower priority first so
    // later assignments override.
    function automatic logic [DATA_W-1:0] forward(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] val;
        val = rf_data;
        if (reg_write_en && (reg_write_dest == addr)) val = reg_write_data;
        if (entry_hits(older_buf, addr))              val = older_buf.data;
        if (entry_hits(younger_buf, addr))            val = younger_buf.data;
        return val;
    endfunction

    // Operand ports see results that are still on their way to the GPRs.
    always_comb begin
        rd_data_1 = forward(rd_addr_1, rf_data_1);
        rd_data_2 = forward(rd_addr_2, rf_data_2);
    end

endmodule

// File: doc/gpr_writeback_unit.md
Name: gpr_writeback_unit

Overview:
- Write-side front end of the 8x8-bit GPRs block. It accepts results from two producers, the ALU and the memory-load path, each over a valid/ready handshake.
- Each producer has a one-entry buffer. The block arbitrates both buffers onto the single GPR write port (reg_write_en/dest/data).
- It also forwards pending, not-yet-written results onto both operand read ports, so decode never sees stale register data.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- STARVE_LIMIT, 3, consecutive lost arbitrations after which the mem buffer is forced to win

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU buffer can accept this cycle
- alu_dest  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load result offered
- mem_ready  output  1  mem buffer can accept this cycle
- mem_dest  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- reg_write_en  output  1  GPR write enable (registered)
- reg_write_dest  output  ADDR_W  GPR write address (registered)
- reg_write_data  output  DATA_W  GPR write data (registered)
- rd_addr_1  input  ADDR_W  operand 1 address; also drives GPR reg_read_addr_1
- rd_addr_2  input  ADDR_W  operand 2 address; also drives GPR reg_read_addr_2
- rf_data_1  input  DATA_W  GPR reg_read_data_1
- rf_data_2  input  DATA_W  GPR reg_read_data_2
- rd_data_1  output  DATA_W  forwarded operand 1
- rd_data_2  output  DATA_W  forwarded operand 2

Behaviour:
- Reset:
  - Both buffers invalid; reg_write_en/dest/data = 0; starvation counter = 0; age bit = 0.
  - alu_ready = mem_ready = 0 while rst is high.
  - Reset mid-operation discards all pending entries and suppresses any write in the following cycle.
- Buffers: one entry each, holding valid, dest and data.
  - x_ready = !rst && (!x_buf_valid || x_buf selected this cycle).
  - Transfer happens on x_valid && x_ready at the clock edge.
- Arbitration (combinational, each cycle):
  - If only one buffer is valid, select it.
  - If both are valid with different dest: select mem if starve_cnt == STARVE_LIMIT, otherwise ALU.
  - If both are valid with the same dest: select the older entry, per the age bit. When both were accepted on the same edge, mem counts as older and is written first.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when mem is valid and not selected.
  - Clears when mem is selected or the mem buffer is empty.
- Write stage:
  - The selected entry loads the write registers at the edge; reg_write_en = 1 the next cycle.
  - With nothing selected, reg_write_en = 0. dest and data hold their last value.
- Latency: accept at edge N, selectable in cycle N+1, reg_write_en high in cycle N+2, GPR updated at edge N+2.
- Throughput: one write per cycle. Sustained dual-source traffic runs at 2 results per 2 cycles with backpressure.
- Forwarding (combinational), per port:
  - Youngest match wins: younger buffer, then older buffer, then the write stage (if reg_write_en), then rf_data_x.
  - A match requires valid && dest == rd_addr_x.
- Address range: all 2**ADDR_W registers are writable; there is no hardwired zero register.

Decomposition:
- Shared package gpr_pkg holds:
  - DATA_W and ADDR_W constants
  - the wb_entry_t struct {valid, dest, data}
  - the src_sel_t enum {SEL_NONE, SEL_ALU, SEL_MEM}
- One sub-module, wb_slot: the single-entry buffer with ready/accept/drain logic, instantiated twice.
- Arbitration, write stage and forwarding stay in the top.

Test Plan:
- Reset hold: rst=1 for 3 cycles with alu_valid=1 -> alu_ready=0, reg_write_en=0, nothing written. After release, r0..r7 read 0.
- Single ALU write: alu dest=3, data=0x5A at edge N -> reg_write_en=1, dest=3, data=0x5A in cycle N+2; rd_addr_1=3 returns 0x5A in cycles N+1 through N+2.
- Same-cycle, same-dest collision: alu(dest 2, 0x11) and mem(dest 2, 0x22) on the same edge -> mem 0x22 written first, ALU 0x11 one cycle later; final r2=0x11; rd_data_1 at addr 2 shows 0x11 throughout.
- Starvation: ALU valid every cycle with distinct dests, mem dest=5, 0x77 held valid -> mem wins after exactly 3 lost cycles; mem_ready low for those cycles.
- Backpressure: both sources valid continuously -> each ready toggles so that exactly one write occurs per cycle; no entry is lost or duplicated (scoreboard check over 50 random transfers).
- Reset mid-flight: accept alu(dest 1, 0xFF), then assert rst the next cycle -> reg_write_en stays 0 and r1 remains 0.
